// File: rtl/verinject_pkg.sv
// Shared definitions for the fault-injection campaign logic: the reserved
// "no injection" bus value and the scheduler FSM state encoding.
package verinject_pkg;

    localparam logic [31:0] IDLE_STATE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_DELAY,
        S_INJECT,
        S_OBSERVE,
        S_NEXT,
        S_DONE
    } inj_sched_state_t;

endpackage

// File: rtl/verinject_sched_timer.sv
// Loadable down-counter shared by the RESET, DELAY and INJECT phases.
// Loading N-1 makes expired rise on the N-th cycle after the load.
module verinject_sched_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/verinject_injection_scheduler.sv
// Campaign sequencer: walks a range of global bit indices, running one
// reset / delay / inject / observe trial per index on the shared injector bus.
module verinject_injection_scheduler #(
    parameter logic [31:0] IDLE_STATE = verinject_pkg::IDLE_STATE,
    parameter int          CNT_W      = 16,
    parameter int          RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_first,
    input  logic [31:0]      cfg_last,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_hold,
    input  logic             trial_done,
    input  logic             trial_fail,
    output logic [31:0]      verinject__injector_state,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic [31:0]      cur_index,
    output logic [31:0]      fail_count,
    output logic [31:0]      trial_count
);
    import verinject_pkg::*;

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    inj_sched_state_t state, state_n;

    logic [31:0]      last_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] hold_q;
    logic [31:0]      last_in;
    logic             in_busy;
    logic             latch, count_trial, step_index;
    logic             timer_load, timer_expired;
    logic [CNT_W-1:0] timer_value;

    // The reserved idle value can never be walked to, so clamp the range end.
    assign last_in = (cfg_last == IDLE_STATE) ? (IDLE_STATE - 32'd1) : cfg_last;
    assign in_busy = (state != S_IDLE) && (state != S_DONE);
    assign busy    = in_busy;
    assign done    = (state == S_DONE);

    verinject_sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    always_comb begin
        state_n     = state;
        latch       = 1'b0;
        count_trial = 1'b0;
        step_index  = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    latch = 1'b1;
                    if (cfg_first > last_in) begin
                        state_n = S_DONE;
                    end else begin
                        state_n     = S_RESET;
                        timer_load  = 1'b1;
                        timer_value = RST_LOAD;
                    end
                end
            end
            S_RESET: begin
                if (timer_expired) begin
                    timer_load = 1'b1;
                    if (delay_q == '0) begin
                        state_n     = S_INJECT;
                        timer_value = hold_q - 1'b1;
                    end else begin
                        state_n     = S_DELAY;
                        timer_value = delay_q - 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (timer_expired) begin
                    state_n     = S_INJECT;
                    timer_load  = 1'b1;
                    timer_value = hold_q - 1'b1;
                end
            end
            S_INJECT: begin
                if (timer_expired) begin
                    state_n = S_OBSERVE;
                end
            end
            S_OBSERVE: begin
                if (trial_done) begin
                    state_n     = S_NEXT;
                    count_trial = 1'b1;
                end
            end
            S_NEXT: begin
                if (cur_index == last_q) begin
                    state_n = S_DONE;
                end else begin
                    state_n     = S_RESET;
                    step_index  = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = RST_LOAD;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle verdict.
        if (abort && in_busy) begin
            state_n     = S_DONE;
            count_trial = 1'b0;
            step_index  = 1'b0;
            timer_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= S_IDLE;
            verinject__injector_state <= IDLE_STATE;
            dut_rst                   <= 1'b1;
            cur_index                 <= '0;
            fail_count                <= '0;
            trial_count               <= '0;
        end else begin
            state                     <= state_n;
            verinject__injector_state <= (state == S_INJECT && !abort) ? cur_index : IDLE_STATE;
            dut_rst                   <= (state_n == S_IDLE) || (state_n == S_RESET) ||
                                         (state_n == S_DONE);
            if (latch) begin
                cur_index   <= cfg_first;
                fail_count  <= '0;
                trial_count <= '0;
            end else begin
                if (step_index) begin
                    cur_index <= cur_index + 32'd1;
                end
                if (count_trial) begin
                    trial_count <= trial_count + 32'd1;
                    if (trial_fail && (fail_count != 32'hFFFF_FFFF)) begin
                        fail_count <= fail_count + 32'd1;
                    end
                end
            end
        end
    end

    // Campaign configuration is data only; it is always written before use.
    always_ff @(posedge clk) begin
        if (latch) begin
            last_q  <= last_in;
            delay_q <= cfg_delay;
            hold_q  <= (cfg_hold == '0) ? CNT_W'(1) : cfg_hold;
        end
    end

endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// Self-checking bench for the injection scheduler: a trial-timeline model
// checked every cycle, directed scenarios with literal expectations, random campaigns.
module tb_verinject_injection_scheduler;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, td = 1'b0, tf = 1'b0;
    logic [31:0] cfg_first = '0, cfg_last = '0;
    logic [15:0] cfg_delay = '0, cfg_hold = '0;
    logic [31:0] bus, cur_index, fail_count, trial_count;
    logic        dut_rst, busy, done;

    verinject_injection_scheduler dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .abort                     (abort),
        .cfg_first                 (cfg_first),
        .cfg_last                  (cfg_last),
        .cfg_delay                 (cfg_delay),
        .cfg_hold                  (cfg_hold),
        .trial_done                (td),
        .trial_fail                (tf),
        .verinject__injector_state (bus),
        .dut_rst                   (dut_rst),
        .busy                      (busy),
        .done                      (done),
        .cur_index                 (cur_index),
        .fail_count                (fail_count),
        .trial_count               (trial_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          c;
        logic [31:0] v;
    } ev_t;
    ev_t blog[$];

    // Model: campaign phase plus t = cycles since the current trial's reset began.
    typedef enum logic [1:0] {M_IDLE, M_TRIAL, M_NEXT, M_DONE} mphase_t;
    mphase_t     ph = M_IDLE;
    int          t = 0, m_d = 0, m_h = 1;
    logic [31:0] m_last = '0;
    logic [31:0] e_bus = IDLE, e_idx = '0, e_tc = '0, e_fc = '0;
    bit          e_rst = 1'b1;

    function automatic bit m_inject();
        return ph == M_TRIAL && t >= R + m_d && t < R + m_d + m_h;
    endfunction

    function automatic bit m_observe();
        return ph == M_TRIAL && t >= R + m_d + m_h;
    endfunction

    task automatic model_reset();
        ph = M_IDLE; t = 0; e_bus = IDLE; e_rst = 1'b1;
        e_idx = '0; e_tc = '0; e_fc = '0;
    endtask

    task automatic model_step();
        bit          inj    = m_inject();
        bit          killed = (ph == M_TRIAL || ph == M_NEXT) && abort;
        logic [31:0] idx    = e_idx;
        if (killed) begin
            ph = M_DONE;
        end else begin
            case (ph)
                M_IDLE, M_DONE: if (start) begin
                    m_last = (cfg_last == IDLE) ? IDLE - 32'd1 : cfg_last;
                    m_d    = int'(cfg_delay);
                    m_h    = (cfg_hold == 16'd0) ? 1 : int'(cfg_hold);
                    e_idx  = cfg_first; e_tc = '0; e_fc = '0;
                    if (cfg_first > m_last) ph = M_DONE;
                    else begin ph = M_TRIAL; t = 0; end
                end
                M_TRIAL: if (m_observe() && td) begin
                    e_tc = e_tc + 32'd1;
                    if (tf && e_fc != IDLE) e_fc = e_fc + 32'd1;
                    ph = M_NEXT;
                end else t++;
                M_NEXT: if (e_idx == m_last) ph = M_DONE;
                        else begin e_idx = e_idx + 32'd1; ph = M_TRIAL; t = 0; end
                default: ph = M_IDLE;
            endcase
        end
        e_bus = (inj && !killed) ? idx : IDLE;
        e_rst = (ph == M_IDLE) || (ph == M_DONE) || (ph == M_TRIAL && t < R);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check("bus", bus, e_bus);
        check("dut_rst", 32'(dut_rst), 32'(e_rst));
        check("busy", 32'(busy), 32'(ph == M_TRIAL || ph == M_NEXT));
        check("done", 32'(done), 32'(ph == M_DONE));
        check("cur_index", cur_index, e_idx);
        check("fail_count", fail_count, e_fc);
        check("trial_count", trial_count, e_tc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        cyc++;
        @(negedge clk);
        if (chk_en) compare_all();
        if (bus !== IDLE) blog.push_back('{cyc, bus});
        start = 1'b0; abort = 1'b0; td = 1'b0; tf = 1'b0;
    endtask

    function automatic logic [31:0] getv(int i);
        if (i < int'(blog.size())) return blog[i].v;
        return IDLE;
    endfunction

    function automatic int getc(int i);
        if (i < int'(blog.size())) return blog[i].c;
        return -1000;
    endfunction

    task automatic run_done(int budget, bit fail_second);
        for (int i = 0; i < budget && ph != M_DONE; i++) begin
            td = 1'b1;
            tf = fail_second && (e_tc == 32'd1);
            tick();
        end
        check("reach_done", 32'(done), 32'd1);
    endtask

    task automatic set_cfg(logic [31:0] f, logic [31:0] l, int d, int h);
        cfg_first = f; cfg_last = l; cfg_delay = 16'(d); cfg_hold = 16'(h);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_bus"}, bus, 32'hFFFF_FFFF);
        check({tag, "_dut_rst"}, 32'(dut_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cur"}, cur_index, 32'd0);
        check({tag, "_fails"}, fail_count, 32'd0);
        check({tag, "_trials"}, trial_count, 32'd0);
    endtask

    int s;

    initial begin
        repeat (2) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Three-index walk with one failing verdict.
        set_cfg(32'd5, 32'd7, 3, 1);
        blog.delete(); s = cyc; start = 1'b1; tick();
        run_done(300, 1'b1);
        check("t1_n_inj", 32'(blog.size()), 32'd3);
        check("t1_first_cycle", 32'(getc(0) - s), 32'd9);
        check("t1_v0", getv(0), 32'd5);
        check("t1_v1", getv(1), 32'd6);
        check("t1_v2", getv(2), 32'd7);
        check("t1_trials", trial_count, 32'd3);
        check("t1_fails", fail_count, 32'd1);

        // Hold of 0 behaves as 1, then a 4-cycle hold.
        set_cfg(32'd0, 32'd0, 1, 0);
        blog.delete(); start = 1'b1; tick();
        run_done(100, 1'b0);
        check("t2_hold0_len", 32'(blog.size()), 32'd1);
        check("t2_hold0_v", getv(0), 32'd0);
        set_cfg(32'd0, 32'd0, 1, 4);
        blog.delete(); start = 1'b1; tick();
        run_done(100, 1'b0);
        check("t2_hold4_len", 32'(blog.size()), 32'd4);
        check("t2_hold4_v3", getv(3), 32'd0);
        check("t2_hold4_span", 32'(getc(3) - getc(0)), 32'd3);

        // Empty range.
        set_cfg(32'd10, 32'd9, 0, 1);
        blog.delete(); start = 1'b1; tick();
        check("t3_done", 32'(done), 32'd1);
        check("t3_trials", trial_count, 32'd0);
        check("t3_fails", fail_count, 32'd0);
        repeat (3) tick();
        check("t3_no_inj", 32'(blog.size()), 32'd0);

        // Abort in the middle of index 2's injection window.
        set_cfg(32'd0, 32'd5, 2, 3);
        start = 1'b1; tick();
        for (int i = 0; i < 300 && !(ph == M_TRIAL && e_idx == 32'd2 && t == R + m_d + 1); i++) begin
            td = 1'b1; tick();
        end
        check("t4_bus_pre", bus, 32'd2);
        abort = 1'b1; td = 1'b1; tick();
        check("t4_bus", bus, 32'hFFFF_FFFF);
        check("t4_dut_rst", 32'(dut_rst), 32'd1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_trials", trial_count, 32'd2);

        // Verdicts outside OBSERVE are ignored.
        set_cfg(32'd0, 32'd0, 3, 2);
        start = 1'b1; tick();
        for (int i = 0; i < 50 && !(ph == M_TRIAL && t == R); i++) tick();
        td = 1'b1; tick();
        for (int i = 0; i < 50 && !(ph == M_TRIAL && t == R + m_d); i++) tick();
        td = 1'b1; tf = 1'b1; tick();
        check("t5_trials_early", trial_count, 32'd0);
        for (int i = 0; i < 50 && !m_observe(); i++) tick();
        td = 1'b1; tf = 1'b1; tick();
        check("t5_trials", trial_count, 32'd1);
        check("t5_fails", fail_count, 32'd1);
        for (int i = 0; i < 20 && ph != M_DONE; i++) tick();
        check("t5_done", 32'(done), 32'd1);

        // Asynchronous reset mid-DELAY, then restart.
        set_cfg(32'd3, 32'd4, 5, 1);
        start = 1'b1; tick();
        for (int i = 0; i < 50 && !(ph == M_TRIAL && t == R + 1); i++) tick();
        check("t6_cur_pre", cur_index, 32'd3);
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async");
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; tick();
        check("t6_restart_cur", cur_index, 32'd3);
        check("t6_restart_busy", 32'(busy), 32'd1);
        run_done(300, 1'b0);
        check("t6_trials", trial_count, 32'd2);

        // Random campaigns with scrambled cfg, stray starts, aborts and verdicts.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] f, l;
            if (k % 8 == 7) begin
                f = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                l = (k % 16 == 7) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            end else begin
                f = 32'($urandom_range(0, 20));
                l = f + 32'($urandom_range(0, 3)) - 32'($urandom_range(0, 4) == 0);
            end
            set_cfg(f, l, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            start = 1'b1; tick();
            for (int i = 0; i < 600 && ph != M_DONE; i++) begin
                cfg_first = $urandom; cfg_last = $urandom;
                cfg_delay = 16'($urandom); cfg_hold = 16'($urandom);
                td    = ($urandom_range(0, 2) == 0);
                tf    = $urandom_range(0, 1) == 1;
                abort = ($urandom_range(0, 149) == 0);
                start = ($urandom_range(0, 49) == 0);
                tick();
            end
            check("rand_done", 32'(done), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
